// File: rtl/cond_logic_if.sv
`default_nettype none
// ============================================================================
// Module      : cond_logic_if
// Description : Decoder-to-datapath bundle for the conditional-execution unit.
//               Counter signals exist only when COND_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface cond_logic_if;
    logic        en;
    logic [3:0]  Cond;
    logic [3:0]  ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS;
    logic        RegWrite;
    logic        MemWrite;
    logic        PCSrc;
    logic        RegWriteEn;
    logic        MemWriteEn;
    logic        CondEx;
    logic [3:0]  Flags;
`ifdef COND_PERF_EN
    logic        perf_clr;
    logic [15:0] SquashCnt;
    logic [15:0] BranchCnt;

    modport master (
        output en, Cond, ALUFlags, FlagW, PCS, RegWrite, MemWrite, perf_clr,
        input  PCSrc, RegWriteEn, MemWriteEn, CondEx, Flags, SquashCnt, BranchCnt
    );
    modport slave (
        input  en, Cond, ALUFlags, FlagW, PCS, RegWrite, MemWrite, perf_clr,
        output PCSrc, RegWriteEn, MemWriteEn, CondEx, Flags, SquashCnt, BranchCnt
    );
`else
    modport master (
        output en, Cond, ALUFlags, FlagW, PCS, RegWrite, MemWrite,
        input  PCSrc, RegWriteEn, MemWriteEn, CondEx, Flags
    );
    modport slave (
        input  en, Cond, ALUFlags, FlagW, PCS, RegWrite, MemWrite,
        output PCSrc, RegWriteEn, MemWriteEn, CondEx, Flags
    );
`endif
endinterface
`default_nettype wire

// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
// Module      : cond_logic
// Description : ARMv4 conditional-execution unit: NZCV register, condition
//               check, gated write/branch enables. Optional squash/branch
//               counters enabled by defining COND_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_logic (
    input  logic        clk,
    input  logic        reset,
    cond_logic_if.slave bus
);
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;

    logic [1:0] nz_q, nz_d;
    logic [1:0] cv_q, cv_d;
    logic       w_n, w_z, w_c, w_v;
    logic       w_cond_ex;
    logic       w_go;

    assign w_n = nz_q[1];
    assign w_z = nz_q[0];
    assign w_c = cv_q[1];
    assign w_v = cv_q[0];

    // Evaluated against the registered flags so a flag-setting instruction
    // sees the state left by its predecessor.
    always_comb begin
        w_cond_ex = 1'b1;
        case (bus.Cond)
            COND_EQ: w_cond_ex = w_z;
            COND_NE: w_cond_ex = ~w_z;
            COND_CS: w_cond_ex = w_c;
            COND_CC: w_cond_ex = ~w_c;
            COND_MI: w_cond_ex = w_n;
            COND_PL: w_cond_ex = ~w_n;
            COND_VS: w_cond_ex = w_v;
            COND_VC: w_cond_ex = ~w_v;
            COND_HI: w_cond_ex = w_c & ~w_z;
            COND_LS: w_cond_ex = ~w_c | w_z;
            COND_GE: w_cond_ex = (w_n == w_v);
            COND_LT: w_cond_ex = (w_n != w_v);
            COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: w_cond_ex = w_z | (w_n != w_v);
            default: w_cond_ex = 1'b1;
        endcase
    end

    assign w_go           = bus.en & w_cond_ex;
    assign bus.CondEx     = w_cond_ex;
    assign bus.PCSrc      = w_go & bus.PCS;
    assign bus.RegWriteEn = w_go & bus.RegWrite;
    assign bus.MemWriteEn = w_go & bus.MemWrite;
    assign bus.Flags      = {nz_q, cv_q};

    always_comb begin
        nz_d = nz_q;
        cv_d = cv_q;
        if (w_go && bus.FlagW[1]) begin
            nz_d = bus.ALUFlags[3:2];
        end
        if (w_go && bus.FlagW[0]) begin
            cv_d = bus.ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nz_q <= 2'b00;
            cv_q <= 2'b00;
        end else begin
            nz_q <= nz_d;
            cv_q <= cv_d;
        end
    end

`ifdef COND_PERF_EN
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [15:0] squash_cnt_q, squash_cnt_d;
    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic        w_squash;

    // Only count squashes of instructions that would have had a side effect.
    assign w_squash = bus.en & ~w_cond_ex &
                      (bus.PCS | bus.RegWrite | bus.MemWrite | (|bus.FlagW));

    always_comb begin
        squash_cnt_d = squash_cnt_q;
        branch_cnt_d = branch_cnt_q;
        if (bus.perf_clr) begin
            squash_cnt_d = 16'h0000;
            branch_cnt_d = 16'h0000;
        end else begin
            if (w_squash && (squash_cnt_q != CNT_MAX)) begin
                squash_cnt_d = squash_cnt_q + 16'h0001;
            end
            if (bus.PCSrc && (branch_cnt_q != CNT_MAX)) begin
                branch_cnt_d = branch_cnt_q + 16'h0001;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            squash_cnt_q <= 16'h0000;
            branch_cnt_q <= 16'h0000;
        end else begin
            squash_cnt_q <= squash_cnt_d;
            branch_cnt_q <= branch_cnt_d;
        end
    end

    assign bus.SquashCnt = squash_cnt_q;
    assign bus.BranchCnt = branch_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cond_logic.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_logic
// Description : Self-checking bench for cond_logic (vector table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_logic;
    typedef struct {
        logic       en;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] flagw;
        logic       pcs;
        logic       rw;
        logic       mw;
        logic       x_condex;
        logic       x_pcsrc;
        logic       x_rwen;
        logic       x_mwen;
        logic [3:0] x_flags;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   m_squash;
    int   m_branch;
    vec_t vecs [24];
    vec_t sb_q [$];

    cond_logic_if bus ();

    cond_logic dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] cond, input logic [3:0] alu,
                         input logic [1:0] flagw, input logic pcs, input logic rw, input logic mw);
        bus.en       = en;
        bus.Cond     = cond;
        bus.ALUFlags = alu;
        bus.FlagW    = flagw;
        bus.PCS      = pcs;
        bus.RegWrite = rw;
        bus.MemWrite = mw;
    endtask

    task automatic check_counters();
`ifdef COND_PERF_EN
        check("SquashCnt", bus.SquashCnt, m_squash[15:0]);
        check("BranchCnt", bus.BranchCnt, m_branch[15:0]);
`endif
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic apply(input vec_t v);
        vec_t e;
        drive(v.en, v.cond, v.alu, v.flagw, v.pcs, v.rw, v.mw);
        sb_q.push_back(v);
        #4;
        e = sb_q.pop_front();
        check("CondEx", {15'd0, bus.CondEx}, {15'd0, e.x_condex});
        check("PCSrc", {15'd0, bus.PCSrc}, {15'd0, e.x_pcsrc});
        check("RegWriteEn", {15'd0, bus.RegWriteEn}, {15'd0, e.x_rwen});
        check("MemWriteEn", {15'd0, bus.MemWriteEn}, {15'd0, e.x_mwen});
        if (e.en && !e.x_condex && (e.pcs || e.rw || e.mw || (e.flagw != 2'b00)))
            m_squash++;
        if (e.x_pcsrc)
            m_branch++;
        @(posedge clk);
        #1;
        check("Flags", {12'd0, bus.Flags}, {12'd0, e.x_flags});
        check_counters();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_squash = 0;
        m_branch = 0;
        //          en  cond     alu      fw     pcs   rw    mw    cx    pc    rwe   mwe   flags
        vecs[0]  = '{1'b1, 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000};
        vecs[1]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[2]  = '{1'b1, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110};
        vecs[3]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110};
        vecs[4]  = '{1'b1, 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110};
        vecs[5]  = '{1'b1, 4'b1001, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0110};
        vecs[6]  = '{1'b1, 4'b1110, 4'b0011, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0011};
        vecs[7]  = '{1'b1, 4'b1110, 4'b1100, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111};
        vecs[8]  = '{1'b1, 4'b1110, 4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1100};
        vecs[9]  = '{1'b1, 4'b0100, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1100};
        vecs[10] = '{1'b1, 4'b0101, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100};
        vecs[11] = '{1'b1, 4'b1011, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1100};
        vecs[12] = '{1'b1, 4'b1100, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100};
        vecs[13] = '{1'b1, 4'b1101, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1100};
        vecs[14] = '{1'b1, 4'b0011, 4'b0001, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[15] = '{1'b1, 4'b0000, 4'b1111, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
        vecs[16] = '{1'b1, 4'b1111, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001};
        vecs[17] = '{1'b0, 4'b1010, 4'b0000, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001};
        vecs[18] = '{1'b1, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1001};
        vecs[19] = '{1'b1, 4'b1011, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001};
        vecs[20] = '{1'b1, 4'b0110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1001};
        vecs[21] = '{1'b1, 4'b0111, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001};
        vecs[22] = '{1'b1, 4'b0010, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001};
        vecs[23] = '{1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001};

        reset = 1'b1;
        drive(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
`ifdef COND_PERF_EN
        bus.perf_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset Flags", {12'd0, bus.Flags}, 16'h0000);
        check_counters();
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            apply(vecs[i]);
        end

        // Reset in the middle of a flag-setting branch discards its effects.
        drive(1'b1, 4'b1110, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_squash = 0;
        m_branch = 0;
        check("midreset Flags", {12'd0, bus.Flags}, 16'h0000);
        check_counters();
        drive(1'b1, 4'b0001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        #3;
        check("post-reset NE", {15'd0, bus.CondEx}, 16'h0001);
        bus.Cond = 4'b0000;
        #1;
        check("post-reset EQ", {15'd0, bus.CondEx}, 16'h0000);
        @(posedge clk);
        #1;

`ifdef COND_PERF_EN
        // Branch counter saturation followed by clear-over-increment priority.
        drive(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0);
        repeat (65534) @(posedge clk);
        #1;
        check("BranchCnt FFFE", bus.BranchCnt, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("BranchCnt sat", bus.BranchCnt, 16'hFFFF);
        end
        bus.perf_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.perf_clr = 1'b0;
        check("BranchCnt clr", bus.BranchCnt, 16'h0000);
        check("SquashCnt clr", bus.SquashCnt, 16'h0000);
        @(posedge clk);
        #1;
        check("BranchCnt resume", bus.BranchCnt, 16'h0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
